// File: rtl/mem_wb_stage_if.sv
// Memory-to-Writeback bundle: M-stage results and hazard controls in, W-stage register outputs out.
interface mem_wb_stage_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic                  StallW;
    logic                  FlushW;
    logic                  ValidM;
    logic                  RegWriteM;
    logic [1:0]            ResultSrcM;
    logic [REG_ADDR_W-1:0] RdM;
    logic [2:0]            Funct3M;
    logic [WIDTH-1:0]      ALUResultM;
    logic [WIDTH-1:0]      ReadDataM;
    logic [WIDTH-1:0]      PCPlus4M;

    logic                  ValidW;
    logic                  RegWriteW;
    logic [1:0]            ResultSrcW;
    logic [REG_ADDR_W-1:0] RdW;
    logic [WIDTH-1:0]      ALUResultW;
    logic [WIDTH-1:0]      ReadDataW;
    logic [WIDTH-1:0]      PCPlus4W;
    logic [CNT_W-1:0]      RetireCountW;

    modport master (
        output StallW, FlushW, ValidM, RegWriteM, ResultSrcM, RdM, Funct3M,
               ALUResultM, ReadDataM, PCPlus4M,
        input  ValidW, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W,
               RetireCountW
    );

    modport slave (
        input  StallW, FlushW, ValidM, RegWriteM, ResultSrcM, RdM, Funct3M,
               ALUResultM, ReadDataM, PCPlus4M,
        output ValidW, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W,
               RetireCountW
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load-data formatting, stall/flush handling and a retired-instruction
// counter. All outputs are registered.
module mem_wb_stage #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);
    logic                  valid_q;
    logic                  regwrite_q;
    logic [1:0]            resultsrc_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [WIDTH-1:0]      aluresult_q;
    logic [WIDTH-1:0]      readdata_q;
    logic [WIDTH-1:0]      pcplus4_q;
    logic [CNT_W-1:0]      retire_q;

    logic [1:0]       off;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [WIDTH-1:0] load_fmt;
    logic [WIDTH-1:0] readdata_d;

    assign off      = bus.ALUResultM[1:0];
    assign byte_sel = bus.ReadDataM[{off, 3'b000} +: 8];
    // Halfword select uses only off[1]; a misaligned LH is not trapped.
    assign half_sel = bus.ReadDataM[{off[1], 4'b0000} +: 16];

    always_comb begin
        load_fmt = bus.ReadDataM;
        unique case (bus.Funct3M)
            3'b000:  load_fmt = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_fmt = {{(WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_fmt = {{(WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_fmt = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_fmt = bus.ReadDataM;
        endcase
        readdata_d = (bus.ResultSrcM == 2'b01) ? load_fmt : bus.ReadDataM;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            rd_q        <= '0;
            aluresult_q <= '0;
            readdata_q  <= '0;
            pcplus4_q   <= '0;
            retire_q    <= '0;
        end else if (bus.FlushW) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            rd_q        <= '0;
            aluresult_q <= '0;
            readdata_q  <= '0;
            pcplus4_q   <= '0;
        end else if (!bus.StallW) begin
            valid_q     <= bus.ValidM;
            regwrite_q  <= bus.RegWriteM & bus.ValidM & (bus.RdM != '0);
            resultsrc_q <= bus.ResultSrcM;
            rd_q        <= bus.RdM;
            aluresult_q <= bus.ALUResultM;
            readdata_q  <= readdata_d;
            pcplus4_q   <= bus.PCPlus4M;
            retire_q    <= retire_q + CNT_W'(bus.ValidM);
        end
    end

    assign bus.ValidW       = valid_q;
    assign bus.RegWriteW    = regwrite_q;
    assign bus.ResultSrcW   = resultsrc_q;
    assign bus.RdW          = rd_q;
    assign bus.ALUResultW   = aluresult_q;
    assign bus.ReadDataW    = readdata_q;
    assign bus.PCPlus4W     = pcplus4_q;
    assign bus.RetireCountW = retire_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural model of the W registers.
module tb_mem_wb_stage;
    localparam int unsigned WIDTH      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 6;   // narrow counter so wrap is reachable
    localparam logic [63:0] CNT_MAX    = (64'd1 << CNT_W) - 64'd1;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   check_en = 0;

    mem_wb_stage_if #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

    mem_wb_stage #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Load result from the architectural definition: shift the lane down, then extend.
    function automatic logic [31:0] fmt(input logic [31:0] d, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic [31:0] v;
        int          sh;
        case (f3)
            3'd0, 3'd4: begin
                sh = 8 * int'(off);
                v  = (d >> sh) & 32'h0000_00FF;
                if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                sh = (off >= 2'd2) ? 16 : 0;
                v  = (d >> sh) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    // Expected W-stage contents
    logic        m_valid, m_regwrite;
    logic [1:0]  m_src;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdata, m_pc;
    longint      m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 0; m_regwrite <= 0; m_src <= 0; m_rd <= 0;
            m_alu <= 0; m_rdata <= 0; m_pc <= 0; m_cnt <= 0;
        end else if (bus.FlushW) begin
            m_valid <= 0; m_regwrite <= 0; m_src <= 0; m_rd <= 0;
            m_alu <= 0; m_rdata <= 0; m_pc <= 0;
        end else if (!bus.StallW) begin
            m_valid    <= bus.ValidM;
            m_regwrite <= bus.ValidM && bus.RegWriteM && (bus.RdM != 0);
            m_src      <= bus.ResultSrcM;
            m_rd       <= bus.RdM;
            m_alu      <= bus.ALUResultM;
            m_rdata    <= (bus.ResultSrcM == 2'b01) ?
                          fmt(bus.ReadDataM, bus.Funct3M, bus.ALUResultM[1:0]) : bus.ReadDataM;
            m_pc       <= bus.PCPlus4M;
            m_cnt      <= bus.ValidM ? (m_cnt + 1) % (longint'(CNT_MAX) + 1) : m_cnt;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("ValidW",       64'(bus.ValidW),       64'(m_valid));
            check("RegWriteW",    64'(bus.RegWriteW),    64'(m_regwrite));
            check("ResultSrcW",   64'(bus.ResultSrcW),   64'(m_src));
            check("RdW",          64'(bus.RdW),          64'(m_rd));
            check("ALUResultW",   64'(bus.ALUResultW),   64'(m_alu));
            check("ReadDataW",    64'(bus.ReadDataW),    64'(m_rdata));
            check("PCPlus4W",     64'(bus.PCPlus4W),     64'(m_pc));
            check("RetireCountW", 64'(bus.RetireCountW), 64'(m_cnt));
        end
    end

    task automatic drive(input bit v, input bit rw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata);
        bus.StallW     = 0;
        bus.FlushW     = 0;
        bus.ValidM     = v;
        bus.RegWriteM  = rw;
        bus.ResultSrcM = src;
        bus.RdM        = rd;
        bus.Funct3M    = f3;
        bus.ALUResultM = alu;
        bus.ReadDataM  = rdata;
        bus.PCPlus4M   = alu + 32'd4;
    endtask

    task automatic drive_random();
        drive(($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), 5'($urandom),
              3'($urandom), $urandom, $urandom);
        bus.PCPlus4M = $urandom;
        bus.StallW   = ($urandom_range(0, 4) == 0);
        bus.FlushW   = ($urandom_range(0, 9) == 0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } load_t;

    load_t loads[7] = '{
        '{3'b000, 2'd1, 32'h0000_007F},
        '{3'b000, 2'd2, 32'hFFFF_FFFF},
        '{3'b100, 2'd3, 32'h0000_0080},
        '{3'b001, 2'd2, 32'hFFFF_80FF},
        '{3'b101, 2'd0, 32'h0000_7F01},
        '{3'b001, 2'd3, 32'hFFFF_80FF},
        '{3'b010, 2'd1, 32'h80FF_7F01}
    };

    initial begin
        rst = 0;
        drive(0, 0, 2'b00, 5'd0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("reset_count", 64'(bus.RetireCountW), 64'd0);
        rst = 1;
        check_en = 1;

        drive(1, 1, 2'b00, 5'd5, 3'b000, 32'h1234, 32'h0);
        @(negedge clk);
        check("first_valid",  64'(bus.ValidW),       64'd1);
        check("first_rw",     64'(bus.RegWriteW),    64'd1);
        check("first_rd",     64'(bus.RdW),          64'd5);
        check("first_alu",    64'(bus.ALUResultW),   64'h1234);
        check("first_count",  64'(bus.RetireCountW), 64'd1);

        foreach (loads[i]) begin
            drive(1, 1, 2'b01, 5'd7, loads[i].f3, {30'h400, loads[i].off}, 32'h80FF_7F01);
            @(negedge clk);
            check($sformatf("load%0d", i), 64'(bus.ReadDataW), 64'(loads[i].exp));
        end
        check("load_count", 64'(bus.RetireCountW), 64'd8);

        for (int c = 0; c < 3; c++) begin
            drive_random();
            bus.StallW = 1;
            bus.FlushW = 0;
            @(negedge clk);
            check("stall_data",  64'(bus.ReadDataW),    64'h80FF_7F01);
            check("stall_count", 64'(bus.RetireCountW), 64'd8);
        end
        drive(1, 1, 2'b00, 5'd9, 3'b010, 32'hABCD, 32'h0);
        @(negedge clk);
        check("post_stall_alu",   64'(bus.ALUResultW),   64'hABCD);
        check("post_stall_count", 64'(bus.RetireCountW), 64'd9);

        drive(1, 1, 2'b00, 5'd3, 3'b010, 32'h55, 32'h0);
        bus.StallW = 1;
        bus.FlushW = 1;
        @(negedge clk);
        check("flush_valid", 64'(bus.ValidW),       64'd0);
        check("flush_rw",    64'(bus.RegWriteW),    64'd0);
        check("flush_count", 64'(bus.RetireCountW), 64'd9);

        drive(1, 1, 2'b00, 5'd0, 3'b000, 32'h0000_0101, 32'h80FF_7F01);
        @(negedge clk);
        check("x0_rw",    64'(bus.RegWriteW),    64'd0);
        check("x0_valid", 64'(bus.ValidW),       64'd1);
        check("x0_count", 64'(bus.RetireCountW), 64'd10);
        check("raw_data", 64'(bus.ReadDataW),    64'h80FF_7F01);

        for (int k = 0; k < int'(CNT_MAX) - 10; k++) begin
            drive(1, 0, 2'b00, 5'd1, 3'b000, 32'(k), 32'h0);
            @(negedge clk);
        end
        check("count_max", 64'(bus.RetireCountW), CNT_MAX);
        drive(1, 0, 2'b00, 5'd1, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("count_wrap", 64'(bus.RetireCountW), 64'd0);

        for (int k = 0; k < 400; k++) begin
            drive_random();
            @(negedge clk);
        end

        drive(1, 1, 2'b10, 5'd4, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        check("pre_reset_valid", 64'(bus.ValidW), 64'd1);
        #2 rst = 0;
        #1;
        check("async_valid", 64'(bus.ValidW),       64'd0);
        check("async_rw",    64'(bus.RegWriteW),    64'd0);
        check("async_src",   64'(bus.ResultSrcW),   64'd0);
        check("async_rd",    64'(bus.RdW),          64'd0);
        check("async_alu",   64'(bus.ALUResultW),   64'd0);
        check("async_pc",    64'(bus.PCPlus4W),     64'd0);
        check("async_count", 64'(bus.RetireCountW), 64'd0);
        @(negedge clk);
        rst = 1;
        drive(1, 1, 2'b00, 5'd5, 3'b000, 32'h1234, 32'h0);
        @(negedge clk);
        check("rerun_alu",   64'(bus.ALUResultW),   64'h1234);
        check("rerun_count", 64'(bus.RetireCountW), 64'd1);

        check_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the Memory and Writeback stages; it produces every signal the writeback result mux consumes.
- Captures Memory-stage results each cycle, formats load data by width, sign and byte offset, and holds or bubbles on hazard-unit stall and flush.
- Keeps a free-running retired-instruction counter for debug and performance visibility.

Parameters:
- WIDTH, 32, datapath width of the ALU result, read data and PC+4 paths.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- StallW  input  1  hold all W-stage registers.
- FlushW  input  1  insert a bubble into W.
- ValidM  input  1  M stage holds a real instruction.
- RegWriteM  input  1  instruction writes the register file.
- ResultSrcM  input  2  result select: 00 ALU, 01 load data, 10 PC+4.
- RdM  input  REG_ADDR_W  destination register.
- Funct3M  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ALUResultM  input  WIDTH  ALU result / memory address.
- ReadDataM  input  WIDTH  raw aligned word from data memory.
- PCPlus4M  input  WIDTH  PC+4 of the instruction.
- ValidW  output  1  W holds a real instruction.
- RegWriteW  output  1  register-file write enable.
- ResultSrcW  output  2  forwarded to the writeback mux.
- RdW  output  REG_ADDR_W  destination register.
- ALUResultW  output  WIDTH  registered ALU result.
- ReadDataW  output  WIDTH  registered, formatted load data.
- PCPlus4W  output  WIDTH  registered PC+4.
- RetireCountW  output  CNT_W  count of instructions that entered W.

Behaviour:
- Reset: while rst=0, every output is 0 asynchronously, including RetireCountW. Deassertion is clean and the first capture happens on the next rising edge. Reset mid-stream discards the in-flight W contents.
- Latency: exactly one cycle M to W. All outputs are registered; there are no combinational paths from inputs to outputs.
- Priority per edge is FlushW > StallW > normal capture.
- FlushW=1: ValidW=0, RegWriteW=0, ResultSrcW=00, RdW=0. Data registers are don't-care; the implementation clears them to 0.
- StallW=1 with FlushW=0: all outputs hold their values, including RetireCountW.
- Normal capture, control:
  - ValidW = ValidM.
  - RegWriteW = RegWriteM & ValidM & (RdM != 0), so x0 is never written.
  - ResultSrcW = ResultSrcM, passed through unchanged including code 11; the mux resolves 11 to 0.
- Normal capture, data: ALUResultW, PCPlus4W and RdW are copied.
- Load formatting, applied only when ResultSrcM=01; otherwise ReadDataW = ReadDataM raw.
  - Let off = ALUResultM[1:0].
  - LB/LBU: byte ReadDataM[8*off +: 8], sign- or zero-extended to WIDTH.
  - LH/LHU: halfword ReadDataM[16*off[1] +: 16], sign- or zero-extended; off[0] is ignored, and misalignment is not trapped.
  - LW, and the undefined codes 011/110/111: full word, off ignored.
- Retire counter:
  - Increments by 1 on any edge where the W registers capture (no flush, no stall) with ValidM=1.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Simultaneous events: stall+flush means flush; flush with ValidM=1 means no count. A bubble captured (ValidM=0) loads ValidW=0 and RegWriteW=0 without counting.

Test Plan:
- Reset: drive rst=0 mid-run with ValidW=1 -> all outputs 0 immediately without waiting for a clock edge. Release rst, then one valid ALU instruction (RdM=5, ALUResultM=0x1234) -> next cycle ValidW=1, RegWriteW=1, RdW=5, ALUResultW=0x1234, RetireCountW=1.
- Loads with ReadDataM=0x80FF7F01, ResultSrcM=01:
  - LB off=1 -> ReadDataW=0x0000007F.
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LH off=3 -> same as off=2.
  - LW off=1 -> 0x80FF7F01.
- Stall 3 cycles while inputs change -> W outputs and RetireCountW frozen. After release, the new instruction appears one cycle later and the count is +1.
- FlushW=1 and StallW=1 together with ValidM=1, RegWriteM=1 -> next cycle ValidW=0, RegWriteW=0, count unchanged.
- RdM=0 with RegWriteM=1, ValidM=1 -> RegWriteW=0, ValidW=1, count +1. ResultSrcM=00 with Funct3M=000 -> ReadDataW equals raw ReadDataM.
- Force the counter near 2^CNT_W-1, then issue two valid instructions -> RetireCountW reads 2^CNT_W-1, then 0.
